// File: rtl/cpu_defs_pkg.sv
// Shared CPU execute-stage definitions: multiplier state encodings and widths.
package cpu_defs;

   localparam int WORD     = 32;
   localparam int MUL_ITER = 32;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit adder with carry in/out; the only arithmetic element of the multiplier datapath.
module adder_32bit
   import cpu_defs::*;
(
   input  logic [WORD-1:0] in1,
   input  logic [WORD-1:0] in2,
   input  logic            c_in,
   output logic [WORD-1:0] sum,
   output logic            c_out
);

   assign {c_out, sum} = {1'b0, in1} + {1'b0, in2} + {{WORD{1'b0}}, c_in};

endmodule

// File: rtl/mult_seq_32bit.sv
// Sequential 32x32->64 multiplier: radix-2 shift-add (unsigned) or Booth (signed),
// one partial product per clock through a single adder_32bit.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   MUL_IDLE | waiting for start, product holds last result
//   MUL_RUN  | 32 iterations, one partial product per cycle
//   MUL_DONE | single cycle, done pulse, start accepted here
module mult_seq_32bit
   import cpu_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mul_state_t       state;
   logic [WORD-1:0]  a;
   logic [WORD-1:0]  qr;
   logic             q_1;
   logic [WORD-1:0]  mr;
   logic [5:0]       cnt;
   logic             sgn;

   logic [WORD-1:0]  add_in1;
   logic [WORD-1:0]  add_in2;
   logic             add_c_in;
   logic [WORD-1:0]  add_sum;
   logic             add_c_out;
   logic             ovf;
   logic             top;

   adder_32bit u_adder (
      .in1   (add_in1),
      .in2   (add_in2),
      .c_in  (add_c_in),
      .sum   (add_sum),
      .c_out (add_c_out)
   );

   always_comb begin
      add_in1  = '0;
      add_in2  = '0;
      add_c_in = 1'b0;
      if (state == MUL_RUN) begin
         add_in1 = a;
         if (!sgn) begin
            add_in2 = qr[0] ? mr : '0;
         end else begin
            case ({qr[0], q_1})
               2'b01: add_in2 = mr;
               2'b10: begin
                  add_in2  = ~mr;
                  add_c_in = 1'b1;
               end
               default: add_in2 = '0;
            endcase
         end
      end
   end

   // Signed mode needs the true 33-bit sign of A+/-M, not sum[31], so that
   // M = 0x80000000 subtracts correctly.
   assign ovf = (add_in1[WORD-1] == add_in2[WORD-1]) & (add_sum[WORD-1] != add_in1[WORD-1]);
   assign top = sgn ? (add_sum[WORD-1] ^ ovf) : add_c_out;

   assign product = {a, qr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MUL_IDLE;
         a     <= '0;
         qr    <= '0;
         q_1   <= 1'b0;
         mr    <= '0;
         cnt   <= '0;
         sgn   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            MUL_RUN: begin
               a   <= {top, add_sum[WORD-1:1]};
               qr  <= {add_sum[0], qr[WORD-1:1]};
               q_1 <= qr[0];
               cnt <= cnt + 6'd1;
               if (cnt == 6'(MUL_ITER - 1)) begin
                  state <= MUL_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               done <= 1'b0;
               if (start) begin
                  state <= MUL_RUN;
                  busy  <= 1'b1;
                  a     <= '0;
                  qr    <= multiplier;
                  q_1   <= 1'b0;
                  mr    <= multiplicand;
                  cnt   <= '0;
                  sgn   <= signed_op;
               end else begin
                  state <= MUL_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Self-checking bench for mult_seq_32bit: arithmetic reference model plus directed vectors.
module tb_mult_seq_32bit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic [31:0] multiplicand = '0;
   logic [31:0] multiplier = '0;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int checks = 0;
   int errors = 0;

   mult_seq_32bit #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .signed_op    (signed_op),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q,
                                           input logic s);
      longint      sm;
      longint      sq;
      logic [63:0] um;
      logic [63:0] uq;
      if (s) begin
         sm = longint'($signed(m));
         sq = longint'($signed(q));
         return 64'(sm * sq);
      end
      um = {32'b0, m};
      uq = {32'b0, q};
      return um * uq;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: phase 0 = idle, 1..32 = iterating, 33 = done cycle.
   int          phase = 0;
   logic        model_ok = 1'b0;
   logic [63:0] exp_product = '0;
   logic [63:0] pending = '0;

   always @(posedge clk) begin
      if (rst) begin
         phase       <= 0;
         exp_product <= '0;
         model_ok    <= 1'b1;
      end else if ((phase == 0 || phase == 33) && start) begin
         phase   <= 1;
         pending <= ref_mul(multiplicand, multiplier, signed_op);
      end else if (phase >= 1 && phase <= 32) begin
         phase <= phase + 1;
         if (phase == 32) exp_product <= pending;
      end else begin
         phase <= 0;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("busy", 64'(busy), 64'(phase >= 1 && phase <= 32));
         chk("done", 64'(done), 64'(phase == 33));
         if (phase == 0 || phase == 33) chk("product_model", product, exp_product);
      end
   end

   // Drive an operation at the current negedge; return at the negedge of the done cycle.
   task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic s,
                         input logic [63:0] lit, input string name, input bit inject);
      int n;
      start        = 1'b1;
      signed_op    = s;
      multiplicand = m;
      multiplier   = q;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (inject && n == 4) begin
            start        = 1'b1;
            signed_op    = ~s;
            multiplicand = 32'h1234_5678;
            multiplier   = 32'h0BAD_CAFE;
         end
         if (done) break;
      end
      chk({name, "_latency"}, 64'(n), 64'd33);
      chk({name, "_product"}, product, lit);
   endtask

   initial begin
      // pin the model against hand-computed values
      chk("model_u7x6", ref_mul(32'd7, 32'd6, 1'b0), 64'd42);
      chk("model_s_m1x5", ref_mul(32'hFFFF_FFFF, 32'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFFB);
      chk("model_s_min2", ref_mul(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_product", product, 64'd0);

      run_op(32'd7, 32'd6, 1'b0, 64'd42, "u_7x6", 1'b0);
      @(negedge clk);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max", 1'b0);
      repeat (2) @(negedge clk);
      run_op(32'hFFFF_FFE0, 32'hFFFF_FFF5, 1'b1, 64'h160, "s_m32xm11", 1'b0);
      run_op(32'hFFFF_FFFF, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, "s_m1x5", 1'b0);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min2", 1'b0);
      run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_maxmin", 1'b0);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u_msb2", 1'b0);
      @(negedge clk);
      run_op(32'h1234_5678, 32'h10, 1'b0, 64'h1_2345_6780, "ignored_start", 1'b1);
      run_op(32'd3, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, "back_to_back", 1'b0);
      @(negedge clk);

      // abort mid-operation
      start        = 1'b1;
      signed_op    = 1'b0;
      multiplicand = 32'd100;
      multiplier   = 32'd200;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", product, 64'd0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("abort_no_done", 64'(seen), 64'd0);
      end
      run_op(32'd100, 32'd200, 1'b0, 64'd20000, "after_reset", 1'b0);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
